// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port (core / cartridge loader) SDRAM access arbiter with refresh scheduling
//
// Purpose:
//   Arbitrates between a CPU core port and a cartridge-loader write port for a
//   single SDRAM controller. When SDRAM_ARB_REFRESH_EN is defined, it also
//   issues periodic refresh commands and flags a missed refresh deadline.
//   Without the macro, the controller is expected to refresh on its own.
//
// Ports:
//   CLK, RESET           clock, synchronous active-high reset
//   core_req/we/addr/wdata -> core_ack/core_rdata     core access port
//   ld_req/addr/wdata      -> ld_ack                  loader write port
//   dl_active            loader requests are honoured only while high
//   mem_req/we/refresh/addr/wdata, mem_ack/mem_rdata  controller side
//   refresh_overrun      sticky flag: refresh deadline missed
//
// Configuration macro: SDRAM_ARB_REFRESH_EN
module sdram_port_arbiter #(
    parameter int ADDR_W         = 24,
    parameter int DATA_W         = 16,
    parameter int REFRESH_CYCLES = 448
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_ack,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    output logic              ld_ack,
    input  logic              dl_active,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_refresh,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              refresh_overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CORE    = 2'd1,
        LOAD    = 2'd2,
        REFRESH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              last_load_q, last_load_d;   // 1: loader got the last grant, core goes first next
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic              refresh_pending;
    logic              ld_ok;
    logic              in_access;

    assign ld_ok = ld_req && dl_active;

    always_comb begin
        state_d     = state_q;
        last_load_d = last_load_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        case (state_q)
            IDLE: begin
                if (refresh_pending) begin
                    state_d = REFRESH;
                    we_d    = 1'b0;
                end else if (core_req && (last_load_q || !ld_ok)) begin
                    state_d     = CORE;
                    last_load_d = 1'b0;
                    addr_d      = core_addr;
                    wdata_d     = core_wdata;
                    we_d        = core_we;
                end else if (ld_ok) begin
                    state_d     = LOAD;
                    last_load_d = 1'b1;
                    addr_d      = ld_addr;
                    wdata_d     = ld_wdata;
                    we_d        = 1'b1;
                end
            end
            CORE, LOAD, REFRESH: begin
                // The requester's req is not consulted here: an access in
                // flight always runs to its mem_ack.
                if (mem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= IDLE;
            last_load_q <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_load_q <= last_load_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
        end
    end

    // Outputs are forced to zero while RESET is high, so an access abandoned
    // by reset never produces an ack in the reset cycle.
    assign in_access  = (state_q == CORE) || (state_q == LOAD);
    assign mem_req    = !RESET && in_access;
    assign mem_we     = !RESET && in_access && we_q;
    assign mem_addr   = RESET ? '0 : addr_q;
    assign mem_wdata  = RESET ? '0 : wdata_q;
    assign core_ack   = !RESET && (state_q == CORE) && mem_ack;
    assign ld_ack     = !RESET && (state_q == LOAD) && mem_ack;
    assign core_rdata = (core_ack && !we_q) ? mem_rdata : '0;

`ifdef SDRAM_ARB_REFRESH_EN
    localparam int TMR_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_CYCLES - 1);

    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             pending_q, pending_d;
    logic             overrun_q, overrun_d;
    logic             tmr_zero;
    logic             refresh_done;

    assign refresh_done = (state_q == REFRESH) && mem_ack;

    always_comb begin
        tmr_zero  = (tmr_q == '0);
        tmr_d     = tmr_zero ? TMR_RELOAD : tmr_q - TMR_W'(1);
        // A new deadline arriving in the same cycle as the refresh ack is a
        // fresh request, not a miss.
        pending_d = tmr_zero || (pending_q && !refresh_done);
        overrun_d = overrun_q || (tmr_zero && pending_q && !refresh_done);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            tmr_q     <= TMR_RELOAD;
            pending_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            tmr_q     <= tmr_d;
            pending_q <= pending_d;
            overrun_q <= overrun_d;
        end
    end

    assign refresh_pending = pending_q;
    assign mem_refresh     = !RESET && (state_q == REFRESH);
    assign refresh_overrun = !RESET && overrun_q;
`else
    logic unused_cfg;

    assign unused_cfg      = (REFRESH_CYCLES == 0);
    assign refresh_pending = 1'b0;
    assign mem_refresh     = 1'b0;
    assign refresh_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb/tb_sdram_port_arbiter.sv - self-checking bench for sdram_port_arbiter
module tb_sdram_port_arbiter;
    localparam int AW = 24;
    localparam int DW = 16;

    logic          CLK = 1'b0;
    logic          RESET = 1'b1;
    logic          core_req = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_ack;
    logic [DW-1:0] core_rdata;
    logic          ld_req = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [DW-1:0] ld_wdata = '0;
    logic          ld_ack;
    logic          dl_active = 1'b0;
    logic          mem_req, mem_we, mem_refresh;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_ack = 1'b0;
    logic [DW-1:0] mem_rdata = '0;
    logic          refresh_overrun;

    always #5 CLK = ~CLK;

    sdram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .REFRESH_CYCLES(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_ack(core_ack), .core_rdata(core_rdata),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_ack(ld_ack),
        .dl_active(dl_active),
        .mem_req(mem_req), .mem_we(mem_we), .mem_refresh(mem_refresh),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .refresh_overrun(refresh_overrun)
    );

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct {
        logic          c_req, c_we;
        logic [AW-1:0] c_addr;
        logic [DW-1:0] c_wdata;
        logic          l_req;
        logic [AW-1:0] l_addr;
        logic [DW-1:0] l_wdata;
        logic          dl;
        logic [DW-1:0] rdata;
        logic          e_req, e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wdata;
        logic          e_cack, e_lack;
        logic [DW-1:0] e_rdata;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return {2'b00, core_ack, core_rdata, ld_ack, mem_req, mem_we, mem_refresh,
                mem_addr, mem_wdata, refresh_overrun};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        core_req = 1'b0; core_we = 1'b0; core_addr = '0; core_wdata = '0;
        ld_req = 1'b0; ld_addr = '0; ld_wdata = '0; dl_active = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        idle_inputs();
        mem_ack = 1'b1;
        mem_rdata = 16'hFFFF;
        #1;
        chk("rst_outs_zero", all_outs(), 64'd0);
        tick();
        tick();
        idle_inputs();
        RESET = 1'b0;
        #1;
        chk("post_rst_outs_zero", all_outs(), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int grants[4];
        int n_g;
        int cnt_req, cnt_ack, cnt_ref, cnt_ovr;

        vt[0] = '{1'b1, 1'b0, 24'h000100, 16'h5555, 1'b0, 24'h0, 16'h0, 1'b0, 16'hBEEF,
                  1'b1, 1'b0, 24'h000100, 16'h5555, 1'b1, 1'b0, 16'hBEEF};
        vt[1] = '{1'b1, 1'b1, 24'h123456, 16'hA5A5, 1'b0, 24'h0, 16'h0, 1'b0, 16'h7777,
                  1'b1, 1'b1, 24'h123456, 16'hA5A5, 1'b1, 1'b0, 16'h0000};
        vt[2] = '{1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 24'h00ABCD, 16'h1234, 1'b1, 16'h0000,
                  1'b1, 1'b1, 24'h00ABCD, 16'h1234, 1'b0, 1'b1, 16'h0000};
        vt[3] = '{1'b0, 1'b0, 24'h0, 16'h0, 1'b1, 24'h00ABCD, 16'h1234, 1'b0, 16'h3333,
                  1'b0, 1'b0, 24'h000000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vt[4] = '{1'b1, 1'b0, 24'h000200, 16'h1111, 1'b1, 24'h000300, 16'h2222, 1'b1, 16'h4444,
                  1'b1, 1'b1, 24'h000300, 16'h2222, 1'b0, 1'b1, 16'h0000};
        vt[5] = '{1'b1, 1'b0, 24'h000200, 16'h1111, 1'b1, 24'h000300, 16'h2222, 1'b0, 16'h4444,
                  1'b1, 1'b0, 24'h000200, 16'h1111, 1'b1, 1'b0, 16'h4444};

        // Single-grant vectors from a fresh reset
        foreach (vt[i]) begin
            apply_reset();
            core_req = vt[i].c_req; core_we = vt[i].c_we;
            core_addr = vt[i].c_addr; core_wdata = vt[i].c_wdata;
            ld_req = vt[i].l_req; ld_addr = vt[i].l_addr; ld_wdata = vt[i].l_wdata;
            dl_active = vt[i].dl;
            tick();
            chk($sformatf("v%0d_mem_req", i), 64'(mem_req), 64'(vt[i].e_req));
            chk($sformatf("v%0d_mem_we", i), 64'(mem_we), 64'(vt[i].e_we));
            chk($sformatf("v%0d_mem_addr", i), 64'(mem_addr), 64'(vt[i].e_addr));
            chk($sformatf("v%0d_mem_wdata", i), 64'(mem_wdata), 64'(vt[i].e_wdata));
            mem_ack = 1'b1;
            mem_rdata = vt[i].rdata;
            #1;
            chk($sformatf("v%0d_core_ack", i), 64'(core_ack), 64'(vt[i].e_cack));
            chk($sformatf("v%0d_ld_ack", i), 64'(ld_ack), 64'(vt[i].e_lack));
            chk($sformatf("v%0d_core_rdata", i), 64'(core_rdata), 64'(vt[i].e_rdata));
            tick();
            idle_inputs();
            #1;
            chk($sformatf("v%0d_back_idle", i), 64'({core_ack, ld_ack, mem_req}), 64'd0);
        end

        // Core read held for 4 cycles before the controller answers
        apply_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000100;
        tick();
        chk("rd_req_latency", 64'(mem_req), 64'd1);
        core_addr = 24'hFFFFFF;
        for (int c = 0; c < 4; c++) begin
            chk($sformatf("rd_hold_c%0d", c), 64'({mem_req, mem_we, core_ack, mem_addr}),
                64'({1'b1, 1'b0, 1'b0, 24'h000100}));
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        #1;
        chk("rd_core_ack", 64'(core_ack), 64'd1);
        chk("rd_core_rdata", 64'(core_rdata), 64'hBEEF);
        tick();
        mem_ack = 1'b0; core_req = 1'b0;
        #1;
        chk("rd_ack_single_pulse", 64'({core_ack, mem_req}), 64'd0);

        // Loader drops its request mid-access; the ack still arrives
        apply_reset();
        ld_req = 1'b1; dl_active = 1'b1; ld_addr = 24'h000042; ld_wdata = 16'hCAFE;
        tick();
        ld_req = 1'b0; dl_active = 1'b0;
        tick();
        tick();
        chk("drop_still_req", 64'(mem_req), 64'd1);
        mem_ack = 1'b1;
        #1;
        chk("drop_still_ack", 64'(ld_ack), 64'd1);
        tick();
        mem_ack = 1'b0;

        // Both ports requesting continuously: LOAD, CORE, LOAD, CORE
        apply_reset();
        core_req = 1'b1; core_we = 1'b0; core_addr = 24'h000010;
        ld_req = 1'b1; dl_active = 1'b1; ld_addr = 24'h000020;
        n_g = 0;
        for (int c = 0; c < 40 && n_g < 4; c++) begin
            tick();
            if (mem_req) begin
                grants[n_g] = int'(mem_we);
                n_g++;
                mem_ack = 1'b1;
            end else begin
                mem_ack = 1'b0;
            end
        end
        chk("alt_grant_count", 64'(n_g), 64'd4);
        for (int g = 0; g < n_g; g++) begin
            chk($sformatf("alt_grant%0d_is_load", g), 64'(grants[g]), 64'((g % 2) == 0));
        end
        tick();
        idle_inputs();

        // Loader without dl_active is never served
        apply_reset();
        ld_req = 1'b1; dl_active = 1'b0; mem_ack = 1'b1;
        cnt_req = 0; cnt_ack = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            cnt_req += int'(mem_req);
            cnt_ack += int'(ld_ack);
        end
        chk("nodl_mem_req_count", 64'(cnt_req), 64'd0);
        chk("nodl_ld_ack_count", 64'(cnt_ack), 64'd0);
        idle_inputs();

        // Reset during LOAD before the controller acks
        apply_reset();
        ld_req = 1'b1; dl_active = 1'b1; ld_addr = 24'h00BEEF; ld_wdata = 16'h9999;
        tick();
        tick();
        chk("rstld_in_load", 64'(mem_req), 64'd1);
        RESET = 1'b1;
        mem_ack = 1'b1;
        #1;
        chk("rstld_during_outs", all_outs(), 64'd0);
        tick();
        RESET = 1'b0;
        idle_inputs();
        #1;
        chk("rstld_after_outs", all_outs(), 64'd0);
        tick();
        chk("rstld_idle", 64'({mem_req, ld_ack}), 64'd0);

`ifdef SDRAM_ARB_REFRESH_EN
        // Idle bus, refresh acked immediately: one refresh every 16 cycles
        begin
            int first, last, n_iv;
            logic prev;
            apply_reset();
            prev = 1'b0; first = -1; last = -1; n_iv = 0;
            for (int c = 0; c < 70; c++) begin
                tick();
                mem_ack = mem_refresh | mem_req;
                if (mem_refresh && !prev) begin
                    if (first < 0) begin
                        first = c;
                    end else begin
                        chk($sformatf("ref_interval%0d", n_iv), 64'(c - last), 64'd16);
                        n_iv++;
                    end
                    last = c;
                end
                prev = mem_refresh;
            end
            chk("ref_first_cycle", 64'(first), 64'd16);
            chk("ref_interval_count", 64'(n_iv), 64'd3);
            chk("ref_no_overrun", 64'(refresh_overrun), 64'd0);
            idle_inputs();
        end

        // Core access withheld for 40 cycles forces a missed refresh deadline
        apply_reset();
        core_req = 1'b1; core_addr = 24'h000500;
        tick();
        for (int c = 0; c < 40; c++) tick();
        chk("ovr_set", 64'(refresh_overrun), 64'd1);
        mem_ack = 1'b1;
        #1;
        chk("ovr_core_ack", 64'(core_ack), 64'd1);
        tick();
        mem_ack = 1'b0; core_req = 1'b0;
        #1;
        chk("ovr_idle_gap", 64'({mem_refresh, mem_req}), 64'd0);
        tick();
        chk("ovr_refresh_granted", 64'(mem_refresh), 64'd1);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        for (int c = 0; c < 5; c++) tick();
        chk("ovr_sticky", 64'(refresh_overrun), 64'd1);
`else
        // Refresh disabled: refresh outputs never assert
        apply_reset();
        mem_ack = 1'b1;
        cnt_ref = 0; cnt_ovr = 0;
        for (int c = 0; c < 40; c++) begin
            tick();
            cnt_ref += int'(mem_refresh);
            cnt_ovr += int'(refresh_overrun);
        end
        chk("noref_refresh_count", 64'(cnt_ref), 64'd0);
        chk("noref_overrun_count", 64'(cnt_ovr), 64'd0);
        idle_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 24, SDRAM byte-address width.
REQ-002 SHALL have parameter DATA_W, default 16, data width.
REQ-003 SHALL have parameter REFRESH_CYCLES, default 448, CLK cycles between refresh requests.
REQ-004 SHALL have the following ports, one per line:
 CLK  in  1  single system clock; all logic rising-edge.
 RESET  in  1  synchronous, active-high reset.
 core_req  in  1  core access request, held until core_ack.
 core_we  in  1  core write (1) / read (0).
 core_addr  in  ADDR_W  core address.
 core_wdata  in  DATA_W  core write data.
 core_ack  out  1  one-cycle completion pulse to core.
 core_rdata  out  DATA_W  read data, valid with core_ack.
 ld_req  in  1  cartridge loader write request, held until ld_ack.
 ld_addr  in  ADDR_W  loader address.
 ld_wdata  in  DATA_W  loader write data.
 ld_ack  out  1  one-cycle completion pulse to loader.
 dl_active  in  1  ROM download in progress.
 mem_req  out  1  request to SDRAM controller.
 mem_we  out  1  write strobe to controller.
 mem_refresh  out  1  refresh command request.
 mem_addr  out  ADDR_W  address to controller.
 mem_wdata  out  DATA_W  write data to controller.
 mem_ack  in  1  one-cycle controller completion.
 mem_rdata  in  DATA_W  controller read data, valid with mem_ack.
 refresh_overrun  out  1  sticky: refresh deadline missed.

Function
REQ-005 SHALL implement FSM states IDLE, CORE, LOAD, REFRESH.
REQ-006 IDLE arbitration priority: pending refresh > loader (if dl_active) > core; loader without dl_active is ignored.
REQ-007 Round-robin between core and loader: after a LOAD grant, a pending core_req wins the next IDLE decision over ld_req (refresh still first).
REQ-008 Grant decision in IDLE; mem_req/mem_refresh asserted from the first cycle of the granted state (1 cycle after request seen in IDLE).
REQ-009 Address, data, we SHALL be latched at grant and held stable on mem_* until mem_ack.
REQ-010 In LOAD, mem_we=1 always; in REFRESH, mem_req=0, mem_refresh=1, mem_we=0.
REQ-011 On mem_ack: core_ack or ld_ack pulses the same cycle (combinational from mem_ack and state), core_rdata=mem_rdata for core reads, state returns to IDLE next cycle.
REQ-012 Back-to-back: at most one access per IDLE visit; minimum 1 IDLE cycle between accesses.
REQ-013 Requester dropping req before ack SHALL not abort an in-flight access; ack is still delivered.
REQ-014 mem_ack while in IDLE SHALL be ignored.
REQ-015 Refresh timer: down-counter, ceil(log2(REFRESH_CYCLES)) bits, reload REFRESH_CYCLES-1 at zero, sets refresh_pending at zero.
REQ-016 refresh_pending cleared on mem_ack in REFRESH; if timer reaches zero while pending still set, refresh_overrun sets and stays set until RESET.
REQ-017 Timer zero and refresh mem_ack in the same cycle: pending stays set (new request), no overrun.

Reset
REQ-018 RESET SHALL force IDLE, round-robin pointer to core, timer to REFRESH_CYCLES-1, pending and refresh_overrun to 0.
REQ-019 During and after reset all outputs SHALL be 0 (mem_addr, mem_wdata, core_rdata included).
REQ-020 RESET mid-access SHALL abandon it; no ack issued for it.

Configuration
REQ-021 Macro SDRAM_ARB_REFRESH_EN: when defined, refresh timer, REFRESH state and refresh_overrun as above.
REQ-022 Without SDRAM_ARB_REFRESH_EN: no timer logic, REFRESH unreachable, mem_refresh and refresh_overrun tied 0 (controller self-refreshes).

Verification
REQ-023 Core read addr 0x000100, controller acks with 0xBEEF after 4 cycles -> mem_req 1 cycle after core_req, core_ack single pulse, core_rdata=0xBEEF.
REQ-024 core_req and ld_req held continuously, dl_active=1 -> grants alternate LOAD, CORE, LOAD, CORE starting with LOAD.
REQ-025 ld_req=1, dl_active=0 -> no mem_req, ld_ack never pulses.
REQ-026 REFRESH_CYCLES=16, idle bus, immediate mem_ack -> mem_refresh every 16 cycles, refresh_overrun=0.
REQ-027 REFRESH_CYCLES=16, core access whose mem_ack is withheld 40 cycles -> refresh_overrun=1 and sticky; REFRESH granted right after core_ack.
REQ-028 RESET asserted during LOAD before mem_ack -> next cycle IDLE, all outputs 0, no ld_ack.
